// File: rtl/regfile_multiport_if.sv
// Register-file access bundle: decode-side read addresses, writeback write port,
// and the file's status flags. Widths follow the attached register file.
interface regfile_multiport_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2
);
    logic                  rfwrite;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic [XLEN/8-1:0]     wstrb;
    logic [NRD*AW-1:0]     raddr;
    logic [NRD*XLEN-1:0]   rdata;
    logic                  rf_ready;
    logic                  wr_drop;

    modport master (
        output rfwrite, waddr, wdata, wstrb, raddr,
        input  rdata, rf_ready, wr_drop
    );

    modport slave (
        input  rfwrite, waddr, wdata, wstrb, raddr,
        output rdata, rf_ready, wr_drop
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with byte-strobed writes and a reset-time clear sequencer.
// Optional macro REGFILE_BYPASS_EN forwards an in-flight write to same-address reads.
module regfile_multiport #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_multiport_if.slave   bus
);

    localparam int unsigned   NB       = XLEN / 8;
    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_IDLE  = 1'b1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [XLEN-1:0]     r_mem [DEPTH];
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [AW-1:0]       r_clr_ptr;
    logic [AW-1:0]       w_clr_ptr_nxt;
    logic                r_rf_ready;
    logic                w_rf_ready_nxt;
    logic                r_wr_drop;
    logic                w_wr_drop_nxt;
    logic                w_clr_we;
    logic                w_addr_ok;
    logic                w_zero_hit;
    logic                w_wr_accept;
    logic [XLEN-1:0]     w_rd [NRD];
    logic [NRD*XLEN-1:0] w_rdata_pk;

    // Write-side qualification shared by the memory update, drop flag and bypass.
    assign w_addr_ok   = {1'b0, bus.waddr} < DEPTH_W;
    assign w_zero_hit  = (ZERO_REG != 0) && (bus.waddr == '0);
    assign w_wr_accept = (r_state == ST_IDLE) && bus.rfwrite && w_addr_ok && !w_zero_hit;
    assign w_wr_drop_nxt = bus.rfwrite && (|bus.wstrb) &&
                           (!r_rf_ready || !w_addr_ok || w_zero_hit);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_rf_ready <= 1'b0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_ptr  <= w_clr_ptr_nxt;
            r_rf_ready <= w_rf_ready_nxt;
            r_wr_drop  <= w_wr_drop_nxt;
        end
    end

    // Clear sequencer: one entry per cycle, then hand over to normal operation.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_ptr_nxt  = r_clr_ptr;
        w_rf_ready_nxt = r_rf_ready;
        w_clr_we       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_ptr == LAST_IDX) begin
                    w_state_nxt    = ST_IDLE;
                    w_rf_ready_nxt = 1'b1;
                    w_clr_ptr_nxt  = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Storage: clear writes take the port while the sequencer runs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_wr_accept) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.wstrb[b]) begin
                        r_mem[bus.waddr][b*8 +: 8] <= bus.wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [XLEN-1:0] w_byp_data;

    // Post-write image of the target entry, merged byte by byte.
    always_comb begin
        w_byp_data = r_mem[bus.waddr];
        for (int b = 0; b < NB; b++) begin
            if (bus.wstrb[b]) begin
                w_byp_data[b*8 +: 8] = bus.wdata[b*8 +: 8];
            end
        end
    end
`endif

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_ok;
        logic [XLEN-1:0] w_stored;

        assign w_ra     = bus.raddr[k*AW +: AW];
        assign w_ok     = r_rf_ready && ({1'b0, w_ra} < DEPTH_W) &&
                          !((ZERO_REG != 0) && (w_ra == '0));
        assign w_stored = r_mem[w_ra];

`ifdef REGFILE_BYPASS_EN
        assign w_rd[k] = !w_ok ? '0 :
                         (w_wr_accept && (w_ra == bus.waddr)) ? w_byp_data : w_stored;
`else
        assign w_rd[k] = w_ok ? w_stored : '0;
`endif
    end

    always_comb begin
        w_rdata_pk = '0;
        for (int k = 0; k < NRD; k++) begin
            w_rdata_pk[k*XLEN +: XLEN] = w_rd[k];
        end
    end

    assign bus.rdata    = w_rdata_pk;
    assign bus.rf_ready = r_rf_ready;
    assign bus.wr_drop  = r_wr_drop;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: a DEPTH=32 zero-register instance and a
// DEPTH=24 instance without the zero register, sharing clock and reset.
module tb_regfile_multiport;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_multiport_if #(.XLEN(32), .AW(5), .NRD(2)) ifa ();
    regfile_multiport_if #(.XLEN(32), .AW(5), .NRD(2)) ifb ();

    regfile_multiport #(.XLEN(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_REG(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    regfile_multiport #(.XLEN(32), .DEPTH(24), .AW(5), .NRD(2), .ZERO_REG(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready_a(output int n);
        n = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (ifa.rf_ready === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int  na;
        int  nb;
        bit  da;
        bit  db;
        logic [31:0] exp_coll;

        rst = 1'b1;
        ifa.rfwrite = 1'b0; ifa.waddr = '0; ifa.wdata = '0; ifa.wstrb = '0; ifa.raddr = '0;
        ifb.rfwrite = 1'b0; ifb.waddr = '0; ifb.wdata = '0; ifb.wstrb = '0; ifb.raddr = '0;

        // Reset state
        step();
        chk("rst_ready_a", {31'b0, ifa.rf_ready}, 32'd0);
        chk("rst_drop_a",  {31'b0, ifa.wr_drop},  32'd0);
        chk("rst_rdata_a", ifa.rdata[31:0],       32'd0);
        rst = 1'b0;

        // Boot clear, with a write attempt while the sequencer is busy
        na = 0; nb = 0; da = 1'b0; db = 1'b0;
        for (int n = 1; n <= 100 && !(da && db); n++) begin
            step();
            if (n == 9) begin
                ifa.rfwrite = 1'b1; ifa.waddr = 5'd3; ifa.wdata = 32'hFFFF_FFFF; ifa.wstrb = 4'hF;
            end
            if (n == 10) begin
                chk("busy_drop", {31'b0, ifa.wr_drop}, 32'd1);
                ifa.rfwrite = 1'b0; ifa.wstrb = 4'h0;
            end
            if (n == 11) chk("busy_drop_clr", {31'b0, ifa.wr_drop}, 32'd0);
            if (!da && ifa.rf_ready === 1'b1) begin da = 1'b1; na = n; end
            if (!db && ifb.rf_ready === 1'b1) begin db = 1'b1; nb = n; end
        end
        chk("boot_ready_a", 32'(na), 32'd32);
        chk("boot_ready_b", 32'(nb), 32'd24);
        ifa.raddr = {5'd3, 5'd3};
        #1;
        chk("busy_x3_zero", ifa.rdata[63:32], 32'd0);

        // Fill with garbage, then reset, then reset again mid-clear
        for (int i = 1; i < 32; i++) begin
            ifa.rfwrite = 1'b1; ifa.waddr = 5'(i); ifa.wdata = 32'hFFFF_FFFF; ifa.wstrb = 4'hF;
            step();
        end
        ifa.rfwrite = 1'b0; ifa.wstrb = 4'h0;
        ifa.raddr = {5'd3, 5'd31};
        #1;
        chk("garbage_x31", ifa.rdata[31:0],  32'hFFFF_FFFF);
        chk("garbage_x3",  ifa.rdata[63:32], 32'hFFFF_FFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 15; i++) step();
        chk("midclr_ready", {31'b0, ifa.rf_ready}, 32'd0);
        chk("midclr_rdata", ifa.rdata[31:0], 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready_a(na);
        chk("restart_ready_a", 32'(na), 32'd32);
        for (int i = 0; i < 32; i++) begin
            ifa.raddr = {5'(i), 5'(i)};
            #1;
            chk("clear_p0", ifa.rdata[31:0],  32'd0);
            chk("clear_p1", ifa.rdata[63:32], 32'd0);
        end

        // Byte strobes
        ifa.rfwrite = 1'b1; ifa.waddr = 5'd5; ifa.wdata = 32'hAABB_CCDD; ifa.wstrb = 4'hF;
        step();
        ifa.wdata = 32'h1122_3344; ifa.wstrb = 4'h5;
        step();
        ifa.rfwrite = 1'b0; ifa.wstrb = 4'h0;
        ifa.raddr = {5'd5, 5'd5};
        #1;
        chk("strb_x5", ifa.rdata[31:0], 32'hAA22_CC44);
        chk("strb_drop", {31'b0, ifa.wr_drop}, 32'd0);

        // Empty strobe is a silent no-op
        ifa.rfwrite = 1'b1; ifa.waddr = 5'd5; ifa.wdata = 32'h0; ifa.wstrb = 4'h0;
        step();
        ifa.rfwrite = 1'b0;
        chk("nostrb_drop", {31'b0, ifa.wr_drop}, 32'd0);
        chk("nostrb_x5", ifa.rdata[63:32], 32'hAA22_CC44);

        // Zero register: dropped, reads 0 even while being written
        ifa.rfwrite = 1'b1; ifa.waddr = 5'd0; ifa.wdata = 32'hFFFF_FFFF; ifa.wstrb = 4'hF;
        ifa.raddr = {5'd0, 5'd0};
        #1;
        chk("x0_during_wr", ifa.rdata[31:0], 32'd0);
        step();
        ifa.rfwrite = 1'b0; ifa.wstrb = 4'h0;
        chk("x0_drop", {31'b0, ifa.wr_drop}, 32'd1);
        chk("x0_read", ifa.rdata[63:32], 32'd0);
        step();
        chk("x0_drop_clr", {31'b0, ifa.wr_drop}, 32'd0);

        // Collision on all ports
        ifa.rfwrite = 1'b1; ifa.waddr = 5'd7; ifa.wdata = 32'h1234_5678; ifa.wstrb = 4'hF;
        step();
        ifa.wdata = 32'hDEAD_BEEF; ifa.wstrb = 4'hC;
        ifa.raddr = {5'd7, 5'd7};
`ifdef REGFILE_BYPASS_EN
        exp_coll = 32'hDEAD_5678;
`else
        exp_coll = 32'h1234_5678;
`endif
        #1;
        chk("coll_p0", ifa.rdata[31:0],  exp_coll);
        chk("coll_p1", ifa.rdata[63:32], exp_coll);
        step();
        ifa.rfwrite = 1'b0; ifa.wstrb = 4'h0;
        #1;
        chk("coll_next_p0", ifa.rdata[31:0],  32'hDEAD_5678);
        chk("coll_next_p1", ifa.rdata[63:32], 32'hDEAD_5678);
        ifa.raddr = {5'd7, 5'd5};
        #1;
        chk("indep_p0", ifa.rdata[31:0],  32'hAA22_CC44);
        chk("indep_p1", ifa.rdata[63:32], 32'hDEAD_5678);

        // DEPTH=24 instance: out-of-range write/read, writable entry 0, last entry
        ifb.rfwrite = 1'b1; ifb.waddr = 5'd30; ifb.wdata = 32'hCAFE_F00D; ifb.wstrb = 4'hF;
        ifb.raddr = {5'd30, 5'd30};
        #1;
        chk("b_oor_during", ifb.rdata[31:0], 32'd0);
        step();
        chk("b_oor_drop", {31'b0, ifb.wr_drop}, 32'd1);
        chk("b_oor_read", ifb.rdata[63:32], 32'd0);
        ifb.waddr = 5'd0; ifb.wdata = 32'h0000_BEEF;
        step();
        ifb.waddr = 5'd23; ifb.wdata = 32'h5A5A_5A5A;
        chk("b_x0_nodrop", {31'b0, ifb.wr_drop}, 32'd0);
        step();
        ifb.rfwrite = 1'b0; ifb.wstrb = 4'h0;
        ifb.raddr = {5'd23, 5'd0};
        #1;
        chk("b_x0_read",  ifb.rdata[31:0],  32'h0000_BEEF);
        chk("b_x23_read", ifb.rdata[63:32], 32'h5A5A_5A5A);
        ifb.raddr = {5'd24, 5'd24};
        #1;
        chk("b_x24_read", ifb.rdata[31:0], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
